// File: rtl/wave_analyzer.sv
// wave_analyzer: recovers period, peak/trough and waveform class from an 8-bit sample stream.
// Optional period averaging over the last 4 periods is enabled by defining WAVE_AVG_EN.
module wave_analyzer #(
    parameter int THRESH   = 128,
    parameter int HYST     = 8,
    parameter int PERIOD_W = 16,
    parameter int STEP_MAX = 4,
    parameter int RAIL     = 3
) (
    input  logic                clk_star,
    input  logic                reset,
    input  logic [7:0]          sample_in,
    input  logic                sample_valid,
    output logic [PERIOD_W-1:0] period,
    output logic [7:0]          amp_max,
    output logic [7:0]          amp_min,
    output logic [1:0]          wave_type,
    output logic                result_valid,
    output logic                lock,
    output logic                timeout
);

    typedef enum logic {IDLE, MEASURE} state_t;

    localparam logic [8:0]          ARM_LVL   = 9'(THRESH - HYST);
    localparam logic [8:0]          CROSS_LVL = 9'(THRESH + HYST);
    localparam logic [7:0]          RAIL_LO   = 8'(RAIL);
    localparam logic [7:0]          RAIL_HI   = 8'(255 - RAIL);
    localparam logic [8:0]          STEP_LIM  = 9'(STEP_MAX);
    localparam logic [PERIOD_W-1:0] CNT_LAST  = {{(PERIOD_W-1){1'b1}}, 1'b0};
    localparam logic [PERIOD_W-1:0] ONE       = {{(PERIOD_W-1){1'b0}}, 1'b1};

    state_t                state;
    logic                  armed;
    logic [PERIOD_W-1:0]   cnt;
    logic [7:0]            run_max;
    logic [7:0]            run_min;
    logic                  sq_ok;
    logic                  tri_ok;
    logic [7:0]            prev;
    logic [PERIOD_W-1:0]   ref_period;
    logic                  have_ref;

    logic                  crossing;
    logic                  arm_hit;
    logic                  off_rail;
    logic [8:0]            diff;
    logic [8:0]            abs_step;
    logic                  step_ok;
    logic [PERIOD_W-1:0]   next_period;
    logic [PERIOD_W-1:0]   pdiff;
    logic                  lock_ok;
    logic [1:0]            next_type;

    assign crossing    = armed && ({1'b0, sample_in} >= CROSS_LVL);
    assign arm_hit     = {1'b0, sample_in} < ARM_LVL;
    assign off_rail    = (sample_in > RAIL_LO) && (sample_in < RAIL_HI);
    assign diff        = {1'b0, sample_in} - {1'b0, prev};
    assign abs_step    = diff[8] ? (~diff + 9'd1) : diff;
    assign step_ok     = abs_step <= STEP_LIM;
    // cnt never exceeds CNT_LAST here, so the +1 already yields the saturated value.
    assign next_period = cnt + ONE;
    assign pdiff       = (next_period >= ref_period) ? (next_period - ref_period)
                                                     : (ref_period - next_period);
    assign lock_ok     = pdiff <= ONE;
    // The crossing sample's step is checked against prev so continuity spans periods.
    assign next_type   = sq_ok ? 2'b01 : ((tri_ok && step_ok) ? 2'b10 : 2'b11);

`ifdef WAVE_AVG_EN
    logic [PERIOD_W-1:0] hist [3];
    logic [1:0]          hist_cnt;
    logic [PERIOD_W+1:0] hist_sum;
    logic [PERIOD_W+1:0] hist_avg;

    assign hist_sum = {2'b00, hist[0]} + {2'b00, hist[1]} + {2'b00, hist[2]}
                    + {2'b00, next_period};
    assign hist_avg = hist_sum >> 2;

    // NOTE: the history array carries no reset; hist_cnt alone says which entries are live.
    always_ff @(posedge clk_star) begin
        if (sample_valid && state == MEASURE && crossing) begin
            hist[2] <= hist[1];
            hist[1] <= hist[0];
            hist[0] <= next_period;
        end
    end
`endif

    // NOTE: every register here uses non-blocking assignment so all updates see pre-edge values.
    always_ff @(posedge clk_star) begin
        if (reset) begin
            state        <= IDLE;
            armed        <= 1'b0;
            cnt          <= '0;
            run_max      <= '0;
            run_min      <= '0;
            sq_ok        <= 1'b0;
            tri_ok       <= 1'b0;
            prev         <= '0;
            ref_period   <= '0;
            have_ref     <= 1'b0;
            period       <= '0;
            amp_max      <= '0;
            amp_min      <= '0;
            wave_type    <= '0;
            result_valid <= 1'b0;
            lock         <= 1'b0;
            timeout      <= 1'b0;
`ifdef WAVE_AVG_EN
            hist_cnt     <= '0;
`endif
        end else begin
            result_valid <= 1'b0;
            timeout      <= 1'b0;
            if (sample_valid) begin
                if (crossing) begin
                    armed <= 1'b0;
                end else if (arm_hit) begin
                    armed <= 1'b1;
                end

                if (crossing) begin
                    // Both IDLE entry and period close seed the trackers from the crossing sample.
                    cnt     <= '0;
                    run_max <= sample_in;
                    run_min <= sample_in;
                    sq_ok   <= 1'b1;
                    tri_ok  <= 1'b1;
                    prev    <= sample_in;
                end

                case (state)
                    IDLE: begin
                        if (crossing) begin
                            state    <= MEASURE;
                            have_ref <= 1'b0;
`ifdef WAVE_AVG_EN
                            hist_cnt <= '0;
`endif
                        end
                    end

                    MEASURE: begin
                        if (crossing) begin
                            amp_max    <= run_max;
                            amp_min    <= run_min;
                            wave_type  <= next_type;
                            ref_period <= next_period;
                            have_ref   <= 1'b1;
                            if (have_ref) begin
                                lock <= lock_ok;
                            end
`ifdef WAVE_AVG_EN
                            if (hist_cnt == 2'd3) begin
                                period       <= hist_avg[PERIOD_W-1:0];
                                result_valid <= 1'b1;
                            end else begin
                                hist_cnt <= hist_cnt + 2'd1;
                            end
`else
                            period       <= next_period;
                            result_valid <= 1'b1;
`endif
                        end else if (cnt == CNT_LAST) begin
                            state    <= IDLE;
                            cnt      <= '0;
                            timeout  <= 1'b1;
                            lock     <= 1'b0;
                            have_ref <= 1'b0;
`ifdef WAVE_AVG_EN
                            hist_cnt <= '0;
`endif
                        end else begin
                            cnt  <= cnt + ONE;
                            prev <= sample_in;
                            if (sample_in > run_max) begin
                                run_max <= sample_in;
                            end
                            if (sample_in < run_min) begin
                                run_min <= sample_in;
                            end
                            if (off_rail) begin
                                sq_ok <= 1'b0;
                            end
                            if (!step_ok) begin
                                tri_ok <= 1'b0;
                            end
                        end
                    end

                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: doc/wave_analyzer.md
Name: wave_analyzer

Overview:
- Receive-side counterpart of the 8-bit waveform generator: consumes a stream of unsigned 8-bit samples and recovers period, peak/trough amplitude and waveform class (square / triangle / other).
- Sits on the sample bus downstream of the generator or an ADC capture path, in the clk_star domain.
- Reports one registered result per detected waveform period.

Parameters:
- THRESH, 128, midpoint crossing level.
- HYST, 8, hysteresis half-width around THRESH.
- PERIOD_W, 16, width of the period counter and period output.
- STEP_MAX, 4, maximum absolute sample-to-sample delta still classified as triangle.
- RAIL, 3, distance from 0 or 255 within which a sample counts as a rail sample.

Ports:
- clk_star  in  1  sample clock.
- reset  in  1  synchronous, active-high reset.
- sample_in  in  8  unsigned sample.
- sample_valid  in  1  sample_in is accepted on a clk_star edge while high.
- period  out  PERIOD_W  accepted samples between consecutive rising crossings.
- amp_max  out  8  largest sample in the last measured period.
- amp_min  out  8  smallest sample in the last measured period.
- wave_type  out  2  00 none, 01 square, 10 triangle, 11 other.
- result_valid  out  1  one-cycle pulse when new results are loaded.
- lock  out  1  high while consecutive periods agree.
- timeout  out  1  one-cycle pulse when the period counter saturates.

Behaviour:
- Interface: one clock, clk_star. Reset is synchronous and active-high on port reset.
- Reset: on any clk_star edge with reset high, all outputs go to 0 and internal state clears (FSM=IDLE, armed=0, counters 0). Reset mid-period discards the partial measurement.
- Sample acceptance: state changes only on an edge with sample_valid=1. With sample_valid=0, everything holds except the pulses, which drop to 0.
- Hysteresis/arming:
  - armed sets when an accepted sample is < THRESH-HYST.
  - A rising crossing is an accepted sample >= THRESH+HYST while armed=1; armed clears on that sample.
  - Samples inside the band change nothing.
- FSM IDLE: first crossing → MEASURE. Clear cnt to 0, set amp_max=amp_min=that sample, set sq_ok=tri_ok=1, store prev=sample. No result.
- FSM MEASURE, per accepted non-crossing sample:
  - cnt+1.
  - Update running max and min.
  - sq_ok clears if the sample is in RAIL+1..254-RAIL.
  - tri_ok clears if |sample-prev| > STEP_MAX, using a 9-bit difference.
  - prev updates to the sample.
- FSM MEASURE, at a crossing:
  - Next edge: period=cnt+1, amp_max/amp_min latched, result_valid=1 for one cycle.
  - wave_type: 01 if sq_ok, else 10 if tri_ok, else 11. Square has priority.
  - The crossing sample seeds the next period; it is not included in the closing period's max/min.
  - Running trackers re-seed the same way as on IDLE entry.
  - Stay in MEASURE.
- Latency: result outputs update on the edge after the crossing sample is accepted (1 cycle).
- Lock:
  - Set when a newly measured period differs from the previous measured period by <=1.
  - Cleared on a larger difference, on timeout, or on reset.
  - The first period after IDLE never sets lock.
- Timeout:
  - cnt reaching 2^PERIOD_W-1 in MEASURE without a crossing pulses timeout for one cycle, clears lock, and returns to IDLE.
  - period, amp and wave_type outputs hold; no result_valid.
- Crossing and saturation on the same sample: the crossing wins, and period=2^PERIOD_W-1 saturated.
- The triangle delta check spans the crossing sample (prev carries over) so continuity is checked across periods.

Optional Feature:
- Macro WAVE_AVG_EN.
- Defined:
  - Keep the last 4 measured periods.
  - period outputs (sum of 4) >> 2, truncated.
  - result_valid is suppressed until 4 periods have been measured since IDLE entry.
  - Timeout or reset empties the history.
  - amp_max, amp_min and wave_type still follow the latest period.
- Not defined: period is the raw latest measurement and no history storage exists.

Test Plan:
1. Reset, then continuous square (128×255, 128×0, repeated, valid=1) → result_valid on the second crossing: period=256, wave_type=01, amp_max=255, amp_min=0; lock=1 after the third crossing.
2. Triangle (0,2,…,254,254,252,…,0 repeated) → period=256, wave_type=10, amp_max=254, amp_min=0, lock=1 after the third crossing.
3. Square from test 1 with sample_valid toggling every cycle → identical period=256; no state change on invalid cycles.
4. Constant 200 after one crossing → timeout pulse after 65535 accepted samples, lock=0, no result_valid, FSM back to IDLE.
5. Noise 122..134 around THRESH=128 → no crossing, no result_valid, period stays 0.
6. Reset asserted mid-period during the square stream → all outputs 0 next cycle; next result_valid only after two new crossings, period=256.
7. With WAVE_AVG_EN: periods 256,256,258,258 → first result_valid after the fourth, period=257.
